// File: rtl/data_sync_hs_if.sv
// data_sync_hs_if: destination-side word stream (valid/ready) leaving the synchroniser.
interface data_sync_hs_if #(parameter int BUS_WIDTH = 8);
    logic [BUS_WIDTH-1:0] sync_bus;
    logic                 sync_valid;
    logic                 sync_ready;
    modport master (output sync_bus, sync_valid, input sync_ready);
    modport slave  (input sync_bus, sync_valid, output sync_ready);
endinterface

// File: rtl/data_sync_hs.sv
// data_sync_hs: request synchroniser that captures a quasi-static source bus into a FWFT FIFO.
module data_sync_hs #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int REQ_MODE   = 0,
    parameter int DEPTH      = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         bus_enable,
    input  logic [BUS_WIDTH-1:0]         Unsync_bus,
    data_sync_hs_if.master               dn,
    output logic                         ack_toggle,
    output logic                         overrun,
    input  logic                         clr_overrun,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int FLW = $clog2(DEPTH + 1);

    logic [NUM_STAGES-1:0] sync_q;
    logic                  prev;
    logic                  s;
    logic                  evt;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [BUS_WIDTH-1:0]  mem [DEPTH];

    assign s = sync_q[NUM_STAGES-1];

    always_comb begin
        evt   = (REQ_MODE != 0) ? (s ^ prev) : (s & ~prev);
        empty = wr_ptr == rd_ptr;
        full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        pop   = ~empty & dn.sync_ready;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push  = evt & (~full | pop);
        drop  = evt & full & ~pop;
    end

    assign dn.sync_bus   = mem[rd_ptr[AW-1:0]];
    assign dn.sync_valid = ~empty;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q     <= '0;
            prev       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ack_toggle <= 1'b0;
            overrun    <= 1'b0;
            fill_level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            sync_q     <= {sync_q[NUM_STAGES-2:0], bus_enable};
            prev       <= s;
            wr_ptr     <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + PW'(1) : rd_ptr;
            ack_toggle <= ack_toggle ^ push;
            overrun    <= drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun);
            fill_level <= (push & ~pop) ? fill_level + FLW'(1) :
                          (pop & ~push) ? fill_level - FLW'(1) : fill_level;
            if (push) mem[wr_ptr[AW-1:0]] <= Unsync_bus;
        end
    end
endmodule

// File: doc/data_sync_hs.md
Name: data_sync_hs

Overview:
- Parametrised successor to the team's multi-cycle-path bus synchroniser. Sits at the destination side of a clock-domain crossing.
- Synchronises an asynchronous request (level or toggle) through NUM_STAGES flops and captures the quasi-static source bus on each detected event.
- Captured words are buffered in a small FIFO and presented downstream with valid/ready.
- Returns an ack toggle to the source domain and flags overruns.

Parameters:
- NUM_STAGES, 2, synchroniser depth for bus_enable; legal >=2.
- BUS_WIDTH, 8, data width.
- REQ_MODE, 0, 0 = level request (event on synchronised rising edge); 1 = toggle request (event on either edge).
- DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- CLK  in  1  destination clock.
- RST  in  1  asynchronous active-low reset.
- bus_enable  in  1  asynchronous request from source domain.
- Unsync_bus  in  BUS_WIDTH  source data; stable from before the bus_enable change until ack_toggle flips.
- sync_bus  out  BUS_WIDTH  FIFO head word.
- sync_valid  out  1  FIFO not empty.
- sync_ready  in  1  downstream accept; pop when sync_valid & sync_ready.
- ack_toggle  out  1  flips once per accepted capture; routed back to source domain.
- overrun  out  1  sticky: an event arrived while FIFO full.
- clr_overrun  in  1  synchronous clear of overrun.
- fill_level  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (RST low, async):
  - Sync chain, edge register and FIFO storage/pointers cleared.
  - sync_bus = 0, sync_valid = 0, ack_toggle = 0, overrun = 0, fill_level = 0.
  - Any in-flight source transfer is lost.
- Sync chain: NUM_STAGES flops, all reset to 0. Output s = last stage. prev = registered copy of s.
- Event detection (combinational):
  - REQ_MODE 0: event = s & ~prev.
  - REQ_MODE 1: event = s ^ prev.
- Latency:
  - bus_enable first sampled at edge k.
  - event is high during the cycle after edge k+NUM_STAGES-1.
  - Push occurs at edge k+NUM_STAGES.
  - sync_valid is high after edge k+NUM_STAGES when the FIFO was empty.
  - ack_toggle flips at the same edge as the push.
- Capture:
  - On event with FIFO not full (or full with a pop in the same cycle): Unsync_bus is written at wr_ptr, wr_ptr increments, ack_toggle flips.
  - On event with FIFO full and no pop: word dropped, ack_toggle does not flip, overrun set to 1.
- FIFO:
  - First-word fall-through: sync_bus = mem[rd_ptr] whenever sync_valid = 1.
  - When empty, sync_bus holds the last head value; do not check it.
  - Pointers have clog2(DEPTH)+1 bits and wrap modulo DEPTH.
  - empty when pointers are equal; full when index bits are equal and MSBs differ.
- Simultaneous push and pop: both performed, fill_level unchanged. Permitted when full and when holding one entry.
- Pop while empty (sync_ready high, sync_valid low): ignored.
- overrun:
  - Cleared by clr_overrun = 1 at the next edge.
  - A set and a clear in the same cycle: set wins.
- fill_level is a registered counter, updated at the push/pop edge, saturating only by construction (never > DEPTH).
- No combinational path from any input to any output except sync_ready, which affects no output in the same cycle.

Test Plan:
- Level mode, NUM_STAGES=2: bus_enable rises with Unsync_bus=0xA5 and is held.
  - -> sync_valid=1 and sync_bus=0xA5 two edges after first sampling; ack_toggle 0->1 at the same edge.
  - -> exactly one push; bus_enable held high generates no further events.
- Toggle mode: four bus_enable flips spaced 6 cycles apart with data 0x11, 0x22, 0x33, 0x44, sync_ready=0.
  - -> fill_level=4, ack_toggle back at 0, overrun=0.
  - -> with sync_ready=1, data pops in order 0x11..0x44, then sync_valid=0.
- Overrun, DEPTH=4: full FIFO, fifth event with 0x55, sync_ready=0.
  - -> overrun=1, ack_toggle unchanged, fill_level=4, 0x55 never appears.
  - -> clr_overrun pulse -> overrun=0 next edge.
  - -> clr_overrun coincident with another overrun -> overrun stays 1.
- Full with simultaneous push and pop: event with 0x66 in the same cycle as a pop.
  - -> fill_level stays 4; 0x66 emerges fourth after the popped word; no overrun.
- Reset mid-operation: assert RST with 3 entries and a request mid-chain.
  - -> all outputs 0 immediately (asynchronously), fill_level=0.
  - -> after release, the still-high level bus_enable produces exactly one new event.
- Wrap-around: push/pop 3*DEPTH words with sync_ready toggled randomly.
  - -> output order matches input order, no loss, sync_valid consistent with fill_level != 0.
